// File: rtl/floppy_pkg.sv
// floppy_pkg: widths and FSM encoding shared by the floppy voice scheduler.
// No ports; imported by floppy_voice and floppy_voice_sched.
package floppy_pkg;

   localparam int NOTE_W     = 7;
   localparam int SETPOINT_W = 23;
   localparam int TRACK_W    = 7;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOOKUP = 2'd1,
      ASSIGN = 2'd2
   } state_t;

endpackage

// File: rtl/floppy_voice.sv
// floppy_voice: one drive voice; half-period down-counter, step/dir, head track.
// Ports: clk, rst (async high), load/kill strobes, period in; step, dir, active out.
module floppy_voice
   import floppy_pkg::*;
#(
   parameter int MAX_TRACK = 79
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic                  kill,
   input  logic [SETPOINT_W-1:0] period,
   output logic                  step,
   output logic                  dir,
   output logic                  active
);

   localparam logic [TRACK_W-1:0] TOP = TRACK_W'(MAX_TRACK);

   logic [SETPOINT_W-1:0] per_q;
   logic [SETPOINT_W-1:0] cnt_q;
   logic [TRACK_W-1:0]    track_q;
   logic [TRACK_W-1:0]    track_nx;
   logic                  step_q;
   logic                  dir_q;
   logic                  act_q;

   assign step   = step_q;
   assign dir    = dir_q;
   assign active = act_q;

   always_comb begin
      track_nx = dir_q ? track_q - 1'b1 : track_q + 1'b1;
   end

   // A load wins over the tick so a retrigger restarts the half-period
   // cleanly; step level, track and dir are left as they are.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         per_q   <= '0;
         cnt_q   <= '0;
         track_q <= '0;
         step_q  <= 1'b0;
         dir_q   <= 1'b0;
         act_q   <= 1'b0;
      end else if (kill) begin
         act_q  <= 1'b0;
         step_q <= 1'b0;
      end else if (load) begin
         act_q <= 1'b1;
         per_q <= period;
         cnt_q <= period - 1'b1;
      end else if (act_q) begin
         if (cnt_q == '0) begin
            cnt_q  <= per_q - 1'b1;
            step_q <= ~step_q;
            // Only the rising edge moves the head.
            if (!step_q) begin
               track_q <= track_nx;
               if (!dir_q && track_nx == TOP) begin
                  dir_q <= 1'b1;
               end else if (dir_q && track_nx == '0) begin
                  dir_q <= 1'b0;
               end
            end
         end else begin
            cnt_q <= cnt_q - 1'b1;
         end
      end
   end

endmodule

// File: rtl/floppy_voice_sched.sv
// floppy_voice_sched: MIDI note events -> floppy drive voices (IDLE/LOOKUP/ASSIGN).
// Ports: clk, rst (async high); note_valid/note_ready/note_on/note event in;
// lut_note/lut_setpoint external lookup; step, dir, active per drive.
// Build option FLOPPY_VOICE_STEAL_EN: a note-on with all voices busy steals
// the voice at a round-robin pointer instead of being dropped.
module floppy_voice_sched
   import floppy_pkg::*;
#(
   parameter int NUM_DRIVES = 4,
   parameter int MAX_TRACK  = 79
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  note_valid,
   output logic                  note_ready,
   input  logic                  note_on,
   input  logic [NOTE_W-1:0]     note,
   output logic [NOTE_W-1:0]     lut_note,
   input  logic [SETPOINT_W-1:0] lut_setpoint,
   output logic [NUM_DRIVES-1:0] step,
   output logic [NUM_DRIVES-1:0] dir,
   output logic [NUM_DRIVES-1:0] active
);

   localparam int PW = (NUM_DRIVES > 1) ? $clog2(NUM_DRIVES) : 1;

   state_t                state_q;
   state_t                state_d;
   logic                  on_q;
   logic [NOTE_W-1:0]     note_q;
   logic [SETPOINT_W-1:0] sp_q;
   logic [NOTE_W-1:0]     vnote_q [NUM_DRIVES];
   logic [NUM_DRIVES-1:0] match;
   logic [NUM_DRIVES-1:0] load;
   logic [NUM_DRIVES-1:0] kill;
   logic                  any_match;
   logic                  any_free;
   logic [PW-1:0]         match_idx;
   logic [PW-1:0]         free_idx;
   logic                  accept;

   assign note_ready = (state_q == IDLE);
   assign accept     = note_valid & note_ready;
   // The latched note doubles as the lookup address, so it holds between events.
   assign lut_note   = note_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         on_q    <= 1'b0;
         note_q  <= '0;
         sp_q    <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            note_q <= note;
            on_q   <= note_on;
         end
         if (state_q == LOOKUP) begin
            sp_q <= lut_setpoint;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (note_valid) state_d = LOOKUP;
         LOOKUP:  state_d = ASSIGN;
         ASSIGN:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      for (int i = 0; i < NUM_DRIVES; i++) begin
         match[i] = active[i] && (vnote_q[i] == note_q);
      end
   end

   // Scan downward so the lowest index wins.
   always_comb begin
      any_match = 1'b0;
      any_free  = 1'b0;
      match_idx = '0;
      free_idx  = '0;
      for (int i = NUM_DRIVES - 1; i >= 0; i--) begin
         if (match[i]) begin
            any_match = 1'b1;
            match_idx = PW'(i);
         end
         if (!active[i]) begin
            any_free = 1'b1;
            free_idx = PW'(i);
         end
      end
   end

`ifdef FLOPPY_VOICE_STEAL_EN
   logic [PW-1:0] steal_q;
   logic          steal_adv;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         steal_q <= '0;
      end else if (steal_adv) begin
         steal_q <= (steal_q == PW'(NUM_DRIVES - 1)) ? '0 : steal_q + 1'b1;
      end
   end
`endif

   always_comb begin
      load = '0;
      kill = '0;
`ifdef FLOPPY_VOICE_STEAL_EN
      steal_adv = 1'b0;
`endif
      if (state_q == ASSIGN) begin
         if (on_q) begin
            // A zero half-period cannot be played; drop it.
            if (sp_q != '0) begin
               if (any_match) begin
                  load[match_idx] = 1'b1;
               end else if (any_free) begin
                  load[free_idx] = 1'b1;
               end
`ifdef FLOPPY_VOICE_STEAL_EN
               else begin
                  load[steal_q] = 1'b1;
                  steal_adv     = 1'b1;
               end
`endif
            end
         end else begin
            kill = match;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_DRIVES; i++) begin
            vnote_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_DRIVES; i++) begin
            if (load[i]) begin
               vnote_q[i] <= note_q;
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_DRIVES; g++) begin : g_voice
      floppy_voice #(
         .MAX_TRACK (MAX_TRACK)
      ) u_voice (
         .clk    (clk),
         .rst    (rst),
         .load   (load[g]),
         .kill   (kill[g]),
         .period (sp_q),
         .step   (step[g]),
         .dir    (dir[g]),
         .active (active[g])
      );
   end

endmodule

// File: tb/tb_floppy_voice_sched.sv
// tb_floppy_voice_sched: directed scenarios with a timestamp-based voice model
// and per-cycle compare of note_ready, lut_note, active, step and dir.
module tb_floppy_voice_sched;

   localparam int ND   = 4;
   localparam int MAXT = 79;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          note_valid = 1'b0;
   logic          note_on = 1'b0;
   logic [6:0]    note = '0;
   logic          note_ready;
   logic [6:0]    lut_note;
   logic [22:0]   lut_setpoint;
   logic [ND-1:0] step;
   logic [ND-1:0] dir;
   logic [ND-1:0] active;

   logic [22:0]   sp_tab [128];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   assign lut_setpoint = sp_tab[lut_note];

   floppy_voice_sched #(
      .NUM_DRIVES (ND),
      .MAX_TRACK  (MAXT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .note_valid   (note_valid),
      .note_ready   (note_ready),
      .note_on      (note_on),
      .note         (note),
      .lut_note     (lut_note),
      .lut_setpoint (lut_setpoint),
      .step         (step),
      .dir          (dir),
      .active       (active)
   );

   task automatic cmp(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   // ---------------- model ----------------
   // Step level of a voice is a square wave anchored at its last (re)load:
   // step(t) = s0 ^ ((t - t0) / sp) mod 2.
   int  cyc = 0;
   bit  m_act   [ND];
   int  m_note  [ND];
   int  m_sp    [ND];
   int  m_t0    [ND];
   bit  m_s0    [ND];
   bit  m_step  [ND];
   int  m_track [ND];
   bit  m_dir   [ND];
   int  m_ptr = 0;
   int  m_lut = 0;
   bit  pend = 0;
   int  acc_cyc = 0;
   bit  p_on = 0;
   int  p_note = 0;
   int  p_sp = 0;

   always @(posedge clk or posedge rst) begin
      bit rdy;
      bit loaded [ND];
      int hit;
      if (rst) begin
         cyc = 0; pend = 0; m_lut = 0; m_ptr = 0;
         for (int i = 0; i < ND; i++) begin
            m_act[i] = 0; m_step[i] = 0; m_dir[i] = 0; m_track[i] = 0;
         end
      end else begin
         cyc++;
         rdy = !pend;
         for (int i = 0; i < ND; i++) loaded[i] = 0;
         if (pend && cyc == acc_cyc + 1) p_sp = int'(sp_tab[p_note]);
         if (pend && cyc == acc_cyc + 2) begin
            pend = 0;
            if (p_on && p_sp != 0) begin
               hit = -1;
               for (int i = ND - 1; i >= 0; i--)
                  if (m_act[i] && m_note[i] == p_note) hit = i;
               if (hit < 0)
                  for (int i = ND - 1; i >= 0; i--)
                     if (!m_act[i]) hit = i;
`ifdef FLOPPY_VOICE_STEAL_EN
               if (hit < 0) begin
                  hit = m_ptr;
                  m_ptr = (m_ptr + 1) % ND;
               end
`endif
               if (hit >= 0) begin
                  m_act[hit] = 1; m_note[hit] = p_note; m_sp[hit] = p_sp;
                  m_t0[hit] = cyc; m_s0[hit] = m_step[hit]; loaded[hit] = 1;
               end
            end else if (!p_on) begin
               for (int i = 0; i < ND; i++)
                  if (m_act[i] && m_note[i] == p_note) begin
                     m_act[i] = 0; m_step[i] = 0; loaded[i] = 1;
                  end
            end
         end
         for (int i = 0; i < ND; i++) begin
            bit ns;
            if (m_act[i] && !loaded[i]) begin
               ns = m_s0[i] ^ bit'(((cyc - m_t0[i]) / m_sp[i]) % 2);
               if (ns && !m_step[i]) begin
                  if (!m_dir[i]) begin
                     m_track[i]++;
                     if (m_track[i] == MAXT) m_dir[i] = 1;
                  end else begin
                     m_track[i]--;
                     if (m_track[i] == 0) m_dir[i] = 0;
                  end
               end
               m_step[i] = ns;
            end
         end
         if (rdy && note_valid) begin
            pend = 1; acc_cyc = cyc; p_on = note_on;
            p_note = int'(note); m_lut = int'(note);
         end
      end
   end

   always @(negedge clk) begin
      logic [ND-1:0] ea, es, ed;
      for (int i = 0; i < ND; i++) begin
         ea[i] = m_act[i]; es[i] = m_step[i]; ed[i] = m_dir[i];
      end
      cmp("note_ready", 32'(note_ready), 32'(!pend));
      cmp("lut_note", 32'(lut_note), 32'(m_lut));
      cmp("active", 32'(active), 32'(ea));
      cmp("step", 32'(step), 32'(es));
      cmp("dir", 32'(dir), 32'(ed));
   end

   // ---------------- stimulus ----------------
   task automatic send(input logic on, input logic [6:0] n);
      note_valid = 1'b1;
      note_on    = on;
      note       = n;
      @(posedge clk);
      #1 note_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      note_valid = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      int rises;
      logic prev;
      for (int i = 0; i < 128; i++) sp_tab[i] = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      cmp("rst_ready", 32'(note_ready), 32'd1);
      cmp("rst_active", 32'(active), 32'd0);
      cmp("rst_lut", 32'(lut_note), 32'd0);

      // single voice, half-period 10
      sp_tab[7'h05] = 23'd10;
      send(1'b1, 7'h05);
      cmp("n05_active", 32'(active), 32'h1);
      repeat (9) @(posedge clk);
      #1 cmp("n05_step_lo", 32'(step[0]), 32'd0);
      @(posedge clk);
      #1 cmp("n05_step_hi", 32'(step[0]), 32'd1);
      repeat (10) @(posedge clk);
      #1 cmp("n05_step_lo2", 32'(step[0]), 32'd0);
      send(1'b1, 7'h70);
      cmp("zero_sp_drop", 32'(active), 32'h1);
      send(1'b0, 7'h05);
      cmp("n05_off_act", 32'(active), 32'h0);
      cmp("n05_off_step", 32'(step), 32'h0);

      // head sweep out to MAX_TRACK and back
      do_reset();
      sp_tab[7'h07] = 23'd2;
      send(1'b1, 7'h07);
      rises = 0;
      prev  = step[0];
      for (int k = 0; k < 400; k++) begin
         @(posedge clk);
         #1;
         if (step[0] && !prev) rises++;
         prev = step[0];
         if (dir[0]) break;
      end
      cmp("sweep_out", 32'(rises), 32'd79);
      rises = 0;
      for (int k = 0; k < 400; k++) begin
         @(posedge clk);
         #1;
         if (step[0] && !prev) rises++;
         prev = step[0];
         if (!dir[0]) break;
      end
      cmp("sweep_back", 32'(rises), 32'd79);
      send(1'b0, 7'h07);

      // retrigger then release
      do_reset();
      sp_tab[7'h22] = 23'd6;
      send(1'b1, 7'h22);
      repeat (4) @(posedge clk);
      #1 send(1'b1, 7'h22);
      cmp("retrig_one", 32'(active), 32'h1);
      repeat (5) @(posedge clk);
      #1 send(1'b0, 7'h22);
      cmp("release_act", 32'(active), 32'h0);
      cmp("release_step", 32'(step), 32'h0);

      // full allocator
      do_reset();
      sp_tab[7'h10] = 23'd3; sp_tab[7'h20] = 23'd4;
      sp_tab[7'h30] = 23'd5; sp_tab[7'h40] = 23'd6;
      sp_tab[7'h50] = 23'd7; sp_tab[7'h60] = 23'd8;
      send(1'b1, 7'h10); send(1'b1, 7'h20);
      send(1'b1, 7'h30); send(1'b1, 7'h40);
      send(1'b1, 7'h50);
      cmp("full_act", 32'(active), 32'hf);
      send(1'b1, 7'h60);
      send(1'b0, 7'h20);
`ifdef FLOPPY_VOICE_STEAL_EN
      cmp("steal_off20", 32'(active), 32'hf);
`else
      cmp("drop_off20", 32'(active), 32'hd);
`endif
      send(1'b0, 7'h50);
`ifdef FLOPPY_VOICE_STEAL_EN
      cmp("steal_off50", 32'(active), 32'he);
`else
      cmp("drop_off50", 32'(active), 32'hd);
`endif

      // note_valid held across two events
      do_reset();
      sp_tab[7'h11] = 23'd5; sp_tab[7'h12] = 23'd5;
      note_valid = 1'b1; note_on = 1'b1; note = 7'h11;
      @(posedge clk);
      #1 note = 7'h12;
      cmp("hold_lut1", 32'(lut_note), 32'h11);
      @(posedge clk);
      #1 cmp("hold_busy", 32'(note_ready), 32'd0);
      @(posedge clk);
      #1 cmp("hold_ready", 32'(note_ready), 32'd1);
      cmp("hold_lut_keep", 32'(lut_note), 32'h11);
      cmp("hold_act1", 32'(active), 32'h1);
      @(posedge clk);
      #1 note_valid = 1'b0;
      cmp("hold_lut2", 32'(lut_note), 32'h12);
      repeat (2) @(posedge clk);
      #1 cmp("hold_act2", 32'(active), 32'h3);

      // reset during ASSIGN, then unmatched note-off
      do_reset();
      sp_tab[7'h33] = 23'd4;
      note_valid = 1'b1; note_on = 1'b1; note = 7'h33;
      @(posedge clk);
      #1 note_valid = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      #1 cmp("mid_rst_ready", 32'(note_ready), 32'd1);
      cmp("mid_rst_act", 32'(active), 32'h0);
      cmp("mid_rst_lut", 32'(lut_note), 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      send(1'b0, 7'h44);
      cmp("off_nomatch_act", 32'(active), 32'h0);
      cmp("off_nomatch_dir", 32'(dir), 32'h0);
      repeat (3) @(posedge clk);
      #1 cmp("off_nomatch_step", 32'(step), 32'h0);

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (limit 500000)");
      $fatal(1);
   end

endmodule
